// File: rtl/dmem_arbiter_pkg.sv
// Shared widths, memory-op encodings and FSM state type for the data-memory arbiter.
package dmem_arbiter_pkg;

  localparam int ADDR_WIDTH  = 32;
  localparam int DATA_WIDTH  = 32;
  localparam int MEM_OP_BITS = 2;

  // NOP is all-zeros so an idle bus reads as "no access" at the ram.
  localparam logic [MEM_OP_BITS-1:0] MEM_OP_NOP   = 2'b00;
  localparam logic [MEM_OP_BITS-1:0] MEM_OP_READ  = 2'b01;
  localparam logic [MEM_OP_BITS-1:0] MEM_OP_WRITE = 2'b10;

  typedef enum logic [1:0] {
    DMEM_ARB_IDLE   = 2'd0,
    DMEM_ARB_ACCESS = 2'd1,
    DMEM_ARB_RESP   = 2'd2
  } dmem_arb_state_e;

  // True only for ops the ram actually understands; anything else is turned into NOP.
  function automatic logic isMemOp(input logic [MEM_OP_BITS-1:0] op);
    return (op == MEM_OP_READ) || (op == MEM_OP_WRITE);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side handshake plus ram-side bus of the data-memory arbiter.
interface dmem_arbiter_if #(
  parameter int NUM_REQ = 2
);
  import dmem_arbiter_pkg::*;

  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ*MEM_OP_BITS-1:0] req_op;
  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata;
  logic [NUM_REQ-1:0]             gnt;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [DATA_WIDTH-1:0]          rsp_rdata;
  logic [ADDR_WIDTH-1:0]          mem_address;
  logic [DATA_WIDTH-1:0]          mem_write_data;
  logic [MEM_OP_BITS-1:0]         mem_op;
  logic [DATA_WIDTH-1:0]          mem_read_data;
  logic                           busy;

  // Arbiter side: consumes requests and ram read data, drives grants, responses and the ram bus.
  modport slave (
    input  req, req_op, req_addr, req_wdata, mem_read_data,
    output gnt, rsp_valid, rsp_rdata, mem_address, mem_write_data, mem_op, busy
  );

  // Requester side: presents requests and observes grants and responses.
  modport master (
    output req, req_op, req_addr, req_wdata,
    input  gnt, rsp_valid, rsp_rdata, busy
  );

endinterface

// File: rtl/dmem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after lastGrant_i, wrapping around.
module dmem_rr_pick #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   lastGrant_i,
  output logic               any_o,
  output logic [IDX_W-1:0]   winner_o
);

  logic [IDX_W-1:0] idx;

  // Scan from the farthest candidate back to the nearest so the nearest set bit is written last and wins.
  always_comb begin
    any_o    = 1'b0;
    winner_o = '0;
    idx      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IDX_W'((int'(lastGrant_i) + k) % NUM_REQ);
      if (req_i[idx]) begin
        any_o    = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single data-memory port between NUM_REQ requesters.
// Every output is registered so the ram sees a stable, glitch-free op/address/data per access.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ACCESS_LAT = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  dmem_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (ACCESS_LAT > 1) ? $clog2(ACCESS_LAT) : 1;

  dmem_arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       lastGrant_q, lastGrant_d;
  logic [NUM_REQ-1:0]     gnt_q, gnt_d;
  logic [NUM_REQ-1:0]     rspValid_q, rspValid_d;
  logic [DATA_WIDTH-1:0]  rspRdata_q, rspRdata_d;
  logic [ADDR_WIDTH-1:0]  memAddress_q, memAddress_d;
  logic [DATA_WIDTH-1:0]  memWriteData_q, memWriteData_d;
  logic [MEM_OP_BITS-1:0] memOp_q, memOp_d;
  logic [MEM_OP_BITS-1:0] capOp_q, capOp_d;
  logic                   busy_q;

  logic                   pickAny;
  logic [IDX_W-1:0]       pick;
  logic [MEM_OP_BITS-1:0] pickOp;
  logic [ADDR_WIDTH-1:0]  pickAddr;
  logic [DATA_WIDTH-1:0]  pickWdata;

  dmem_rr_pick #(.NUM_REQ(NUM_REQ)) uPick (
    .req_i       (bus.req),
    .lastGrant_i (lastGrant_q),
    .any_o       (pickAny),
    .winner_o    (pick)
  );

  assign pickOp    = bus.req_op[int'(pick)*MEM_OP_BITS +: MEM_OP_BITS];
  assign pickAddr  = bus.req_addr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
  assign pickWdata = bus.req_wdata[int'(pick)*DATA_WIDTH +: DATA_WIDTH];

  // Next-state and next-output logic; grants and responses default to zero so they only ever pulse.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    lastGrant_d    = lastGrant_q;
    gnt_d          = '0;
    rspValid_d     = '0;
    rspRdata_d     = rspRdata_q;
    memAddress_d   = memAddress_q;
    memWriteData_d = memWriteData_q;
    memOp_d        = memOp_q;
    capOp_d        = capOp_q;

    unique case (state_q)
      DMEM_ARB_IDLE: begin
        memOp_d = MEM_OP_NOP;
        if (pickAny) begin
          memAddress_d   = pickAddr;
          memWriteData_d = pickWdata;
          memOp_d        = isMemOp(pickOp) ? pickOp : MEM_OP_NOP;
          capOp_d        = pickOp;
          gnt_d[pick]    = 1'b1;
          lastGrant_d    = pick;
          cnt_d          = '0;
          state_d        = DMEM_ARB_ACCESS;
        end
      end
      DMEM_ARB_ACCESS: begin
        if (cnt_q == CNT_W'(ACCESS_LAT - 1)) begin
          rspRdata_d              = (capOp_q == MEM_OP_READ) ? bus.mem_read_data : '0;
          memOp_d                 = MEM_OP_NOP;
          rspValid_d[lastGrant_q] = 1'b1;
          state_d                 = DMEM_ARB_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DMEM_ARB_RESP: begin
        state_d = DMEM_ARB_IDLE;
      end
      default: begin
        memOp_d = MEM_OP_NOP;
        state_d = DMEM_ARB_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight and hands priority back to requester 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= DMEM_ARB_IDLE;
      cnt_q          <= '0;
      lastGrant_q    <= IDX_W'(NUM_REQ - 1);
      gnt_q          <= '0;
      rspValid_q     <= '0;
      rspRdata_q     <= '0;
      memAddress_q   <= '0;
      memWriteData_q <= '0;
      memOp_q        <= MEM_OP_NOP;
      capOp_q        <= MEM_OP_NOP;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      lastGrant_q    <= lastGrant_d;
      gnt_q          <= gnt_d;
      rspValid_q     <= rspValid_d;
      rspRdata_q     <= rspRdata_d;
      memAddress_q   <= memAddress_d;
      memWriteData_q <= memWriteData_d;
      memOp_q        <= memOp_d;
      capOp_q        <= capOp_d;
      busy_q         <= (state_d != DMEM_ARB_IDLE);
    end
  end

  assign bus.gnt            = gnt_q;
  assign bus.rsp_valid      = rspValid_q;
  assign bus.rsp_rdata      = rspRdata_q;
  assign bus.mem_address    = memAddress_q;
  assign bus.mem_write_data = memWriteData_q;
  assign bus.mem_op         = memOp_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance with single-cycle accesses, one with ACCESS_LAT=3.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic clk;
  logic reset_n;
  int   vecs;
  int   errs;

  dmem_arbiter_if #(.NUM_REQ(2)) ifc ();
  dmem_arbiter_if #(.NUM_REQ(2)) ifc3 ();

  dmem_arbiter #(.NUM_REQ(2), .ACCESS_LAT(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc)
  );

  dmem_arbiter #(.NUM_REQ(2), .ACCESS_LAT(3)) dut3 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc3)
  );

  // Tiny ram models: combinational read, write on the clock edge while mem_op is WRITE.
  logic [31:0] memA [0:255];
  logic [31:0] memB [0:255];

  assign ifc.mem_read_data  = memA[ifc.mem_address[7:0]];
  assign ifc3.mem_read_data = memB[ifc3.mem_address[7:0]];

  always @(posedge clk) begin
    if (ifc.mem_op == MEM_OP_WRITE) memA[ifc.mem_address[7:0]] <= ifc.mem_write_data;
    if (ifc3.mem_op == MEM_OP_WRITE) memB[ifc3.mem_address[7:0]] <= ifc3.mem_write_data;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
    ifc.req_op[p*2 +: 2]      = op;
    ifc.req_addr[p*32 +: 32]  = addr;
    ifc.req_wdata[p*32 +: 32] = data;
    ifc.req[p]                = 1'b1;
  endtask

  task automatic drive3(input int p, input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
    ifc3.req_op[p*2 +: 2]      = op;
    ifc3.req_addr[p*32 +: 32]  = addr;
    ifc3.req_wdata[p*32 +: 32] = data;
    ifc3.req[p]                = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(0, MEM_OP_WRITE, 32'h40, 32'hA5A5A5A5);
    drive(1, MEM_OP_WRITE, 32'h44, 32'h5A5A5A5A);
    tick();
    tick();
    vecs++; if (ifc.gnt !== 2'b00) begin errs++; $display("[TB] FAIL rst_gnt got=%b exp=%b", ifc.gnt, 2'b00); end
    vecs++; if (ifc.rsp_valid !== 2'b00) begin errs++; $display("[TB] FAIL rst_rsp_valid got=%b exp=%b", ifc.rsp_valid, 2'b00); end
    vecs++; if (ifc.rsp_rdata !== 32'h0) begin errs++; $display("[TB] FAIL rst_rsp_rdata got=%h exp=%h", ifc.rsp_rdata, 32'h0); end
    vecs++; if (ifc.mem_address !== 32'h0) begin errs++; $display("[TB] FAIL rst_mem_address got=%h exp=%h", ifc.mem_address, 32'h0); end
    vecs++; if (ifc.mem_write_data !== 32'h0) begin errs++; $display("[TB] FAIL rst_mem_wdata got=%h exp=%h", ifc.mem_write_data, 32'h0); end
    vecs++; if (ifc.mem_op !== MEM_OP_NOP) begin errs++; $display("[TB] FAIL rst_mem_op got=%b exp=%b", ifc.mem_op, MEM_OP_NOP); end
    vecs++; if (ifc.busy !== 1'b0) begin errs++; $display("[TB] FAIL rst_busy got=%b exp=%b", ifc.busy, 1'b0); end
    reset_n = 1'b1;
    tick();
    vecs++; if (ifc.gnt !== 2'b01) begin errs++; $display("[TB] FAIL rst_first_gnt got=%b exp=%b", ifc.gnt, 2'b01); end
    vecs++; if (ifc.mem_address !== 32'h40) begin errs++; $display("[TB] FAIL rst_first_addr got=%h exp=%h", ifc.mem_address, 32'h40); end
    ifc.req = 2'b00;
    tick();
    vecs++; if (ifc.rsp_valid !== 2'b01) begin errs++; $display("[TB] FAIL rst_first_rsp got=%b exp=%b", ifc.rsp_valid, 2'b01); end
    tick();
    vecs++; if (ifc.busy !== 1'b0) begin errs++; $display("[TB] FAIL rst_idle_busy got=%b exp=%b", ifc.busy, 1'b0); end
  endtask

  task automatic test_write_read();
    drive(0, MEM_OP_WRITE, 32'h10, 32'hDEADBEEF);
    vecs++; if (ifc.mem_op !== MEM_OP_NOP) begin errs++; $display("[TB] FAIL wr_idle_op got=%b exp=%b", ifc.mem_op, MEM_OP_NOP); end
    tick();
    vecs++; if (ifc.gnt !== 2'b01) begin errs++; $display("[TB] FAIL wr_gnt got=%b exp=%b", ifc.gnt, 2'b01); end
    vecs++; if (ifc.mem_op !== MEM_OP_WRITE) begin errs++; $display("[TB] FAIL wr_mem_op got=%b exp=%b", ifc.mem_op, MEM_OP_WRITE); end
    vecs++; if (ifc.mem_address !== 32'h10) begin errs++; $display("[TB] FAIL wr_addr got=%h exp=%h", ifc.mem_address, 32'h10); end
    vecs++; if (ifc.mem_write_data !== 32'hDEADBEEF) begin errs++; $display("[TB] FAIL wr_wdata got=%h exp=%h", ifc.mem_write_data, 32'hDEADBEEF); end
    vecs++; if (ifc.busy !== 1'b1) begin errs++; $display("[TB] FAIL wr_busy got=%b exp=%b", ifc.busy, 1'b1); end
    ifc.req = 2'b00;
    tick();
    vecs++; if (ifc.rsp_valid !== 2'b01) begin errs++; $display("[TB] FAIL wr_rsp got=%b exp=%b", ifc.rsp_valid, 2'b01); end
    vecs++; if (ifc.gnt !== 2'b00) begin errs++; $display("[TB] FAIL wr_gnt_pulse got=%b exp=%b", ifc.gnt, 2'b00); end
    vecs++; if (ifc.mem_op !== MEM_OP_NOP) begin errs++; $display("[TB] FAIL wr_resp_op got=%b exp=%b", ifc.mem_op, MEM_OP_NOP); end
    tick();
    vecs++; if (ifc.rsp_valid !== 2'b00) begin errs++; $display("[TB] FAIL wr_rsp_pulse got=%b exp=%b", ifc.rsp_valid, 2'b00); end
    vecs++; if (ifc.busy !== 1'b0) begin errs++; $display("[TB] FAIL wr_done_busy got=%b exp=%b", ifc.busy, 1'b0); end
    drive(0, MEM_OP_READ, 32'h10, 32'h0);
    tick();
    vecs++; if (ifc.gnt !== 2'b01) begin errs++; $display("[TB] FAIL rd_gnt got=%b exp=%b", ifc.gnt, 2'b01); end
    vecs++; if (ifc.mem_op !== MEM_OP_READ) begin errs++; $display("[TB] FAIL rd_mem_op got=%b exp=%b", ifc.mem_op, MEM_OP_READ); end
    ifc.req = 2'b00;
    tick();
    vecs++; if (ifc.rsp_valid !== 2'b01) begin errs++; $display("[TB] FAIL rd_rsp got=%b exp=%b", ifc.rsp_valid, 2'b01); end
    vecs++; if (ifc.rsp_rdata !== 32'hDEADBEEF) begin errs++; $display("[TB] FAIL rd_rdata got=%h exp=%h", ifc.rsp_rdata, 32'hDEADBEEF); end
    vecs++; if (ifc.mem_op !== MEM_OP_NOP) begin errs++; $display("[TB] FAIL rd_resp_op got=%b exp=%b", ifc.mem_op, MEM_OP_NOP); end
    tick();
    vecs++; if (ifc.rsp_valid !== 2'b00) begin errs++; $display("[TB] FAIL rd_rsp_pulse got=%b exp=%b", ifc.rsp_valid, 2'b00); end
  endtask

  task automatic test_contention();
    logic [1:0]  expGnt;
    logic [1:0]  expRsp;
    logic [31:0] expData;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    drive(0, MEM_OP_READ, 32'h10, 32'h0);
    drive(1, MEM_OP_WRITE, 32'h30, 32'h12345678);
    for (int c = 1; c <= 11; c++) begin
      tick();
      expGnt  = 2'b00;
      expRsp  = 2'b00;
      expData = 32'h0;
      if (c % 3 == 1) expGnt = ((c / 3) % 2 == 0) ? 2'b01 : 2'b10;
      if (c % 3 == 2) begin
        expRsp  = ((c / 3) % 2 == 0) ? 2'b01 : 2'b10;
        expData = ((c / 3) % 2 == 0) ? 32'hDEADBEEF : 32'h0;
      end
      vecs++; if (ifc.gnt !== expGnt) begin errs++; $display("[TB] FAIL cont_gnt c=%0d got=%b exp=%b", c, ifc.gnt, expGnt); end
      vecs++; if (ifc.rsp_valid !== expRsp) begin errs++; $display("[TB] FAIL cont_rsp c=%0d got=%b exp=%b", c, ifc.rsp_valid, expRsp); end
      if (c % 3 == 2) begin
        vecs++; if (ifc.rsp_rdata !== expData) begin errs++; $display("[TB] FAIL cont_rdata c=%0d got=%h exp=%h", c, ifc.rsp_rdata, expData); end
      end
    end
    ifc.req = 2'b00;
    tick();
    vecs++; if (ifc.busy !== 1'b0) begin errs++; $display("[TB] FAIL cont_idle_busy got=%b exp=%b", ifc.busy, 1'b0); end
  endtask

  task automatic test_access_lat();
    logic [1:0] expOp;
    drive3(0, MEM_OP_WRITE, 32'h20, 32'hCAFEF00D);
    tick();
    ifc3.req = 2'b00;
    repeat (4) tick();
    drive3(0, MEM_OP_READ, 32'h20, 32'h0);
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) ifc3.req = 2'b00;
      expOp = (c <= 3) ? MEM_OP_READ : MEM_OP_NOP;
      vecs++; if (ifc3.mem_op !== expOp) begin errs++; $display("[TB] FAIL lat3_op c=%0d got=%b exp=%b", c, ifc3.mem_op, expOp); end
      if (c <= 3) begin
        vecs++; if (ifc3.mem_address !== 32'h20) begin errs++; $display("[TB] FAIL lat3_addr c=%0d got=%h exp=%h", c, ifc3.mem_address, 32'h20); end
      end
      vecs++; if (ifc3.gnt !== ((c == 1) ? 2'b01 : 2'b00)) begin errs++; $display("[TB] FAIL lat3_gnt c=%0d got=%b", c, ifc3.gnt); end
      vecs++; if (ifc3.rsp_valid !== ((c == 4) ? 2'b01 : 2'b00)) begin errs++; $display("[TB] FAIL lat3_rsp c=%0d got=%b", c, ifc3.rsp_valid); end
      vecs++; if (ifc3.busy !== (c <= 4)) begin errs++; $display("[TB] FAIL lat3_busy c=%0d got=%b exp=%b", c, ifc3.busy, (c <= 4)); end
      if (c == 4) begin
        vecs++; if (ifc3.rsp_rdata !== 32'hCAFEF00D) begin errs++; $display("[TB] FAIL lat3_rdata got=%h exp=%h", ifc3.rsp_rdata, 32'hCAFEF00D); end
      end
    end
  endtask

  task automatic test_reset_mid_access();
    drive3(0, MEM_OP_WRITE, 32'h24, 32'h0BADF00D);
    tick();
    vecs++; if (ifc3.mem_op !== MEM_OP_WRITE) begin errs++; $display("[TB] FAIL mid_pre_op got=%b exp=%b", ifc3.mem_op, MEM_OP_WRITE); end
    ifc3.req = 2'b00;
    tick();
    reset_n = 1'b0;
    #1;
    vecs++; if (ifc3.mem_op !== MEM_OP_NOP) begin errs++; $display("[TB] FAIL mid_rst_op got=%b exp=%b", ifc3.mem_op, MEM_OP_NOP); end
    vecs++; if (ifc3.busy !== 1'b0) begin errs++; $display("[TB] FAIL mid_rst_busy got=%b exp=%b", ifc3.busy, 1'b0); end
    for (int c = 0; c < 2; c++) begin
      tick();
      vecs++; if (ifc3.rsp_valid !== 2'b00) begin errs++; $display("[TB] FAIL mid_rst_rsp c=%0d got=%b exp=%b", c, ifc3.rsp_valid, 2'b00); end
    end
    reset_n = 1'b1;
    drive3(0, MEM_OP_READ, 32'h20, 32'h0);
    drive3(1, MEM_OP_READ, 32'h24, 32'h0);
    tick();
    vecs++; if (ifc3.gnt !== 2'b01) begin errs++; $display("[TB] FAIL mid_fresh_gnt got=%b exp=%b", ifc3.gnt, 2'b01); end
    ifc3.req = 2'b00;
    for (int c = 2; c <= 4; c++) begin
      tick();
      vecs++; if (ifc3.rsp_valid !== ((c == 4) ? 2'b01 : 2'b00)) begin errs++; $display("[TB] FAIL mid_fresh_rsp c=%0d got=%b", c, ifc3.rsp_valid); end
    end
    vecs++; if (ifc3.rsp_rdata !== 32'hCAFEF00D) begin errs++; $display("[TB] FAIL mid_fresh_rdata got=%h exp=%h", ifc3.rsp_rdata, 32'hCAFEF00D); end
    tick();
  endtask

  task automatic test_illegal_op();
    drive(0, MEM_OP_READ, 32'h10, 32'h0);
    tick();
    ifc.req = 2'b00;
    tick();
    vecs++; if (ifc.rsp_rdata !== 32'hDEADBEEF) begin errs++; $display("[TB] FAIL ill_pre_rdata got=%h exp=%h", ifc.rsp_rdata, 32'hDEADBEEF); end
    tick();
    drive(1, 2'b11, 32'h10, 32'h77777777);
    tick();
    vecs++; if (ifc.gnt !== 2'b10) begin errs++; $display("[TB] FAIL ill_gnt got=%b exp=%b", ifc.gnt, 2'b10); end
    vecs++; if (ifc.mem_op !== MEM_OP_NOP) begin errs++; $display("[TB] FAIL ill_access_op got=%b exp=%b", ifc.mem_op, MEM_OP_NOP); end
    ifc.req = 2'b00;
    tick();
    vecs++; if (ifc.rsp_valid !== 2'b10) begin errs++; $display("[TB] FAIL ill_rsp got=%b exp=%b", ifc.rsp_valid, 2'b10); end
    vecs++; if (ifc.rsp_rdata !== 32'h0) begin errs++; $display("[TB] FAIL ill_rdata got=%h exp=%h", ifc.rsp_rdata, 32'h0); end
    vecs++; if (ifc.mem_op !== MEM_OP_NOP) begin errs++; $display("[TB] FAIL ill_resp_op got=%b exp=%b", ifc.mem_op, MEM_OP_NOP); end
    tick();
    vecs++; if (ifc.busy !== 1'b0) begin errs++; $display("[TB] FAIL ill_idle_busy got=%b exp=%b", ifc.busy, 1'b0); end
  endtask

  // Runs every scenario in order and prints the single summary line.
  initial begin
    vecs           = 0;
    errs           = 0;
    reset_n        = 1'b0;
    ifc.req        = '0;
    ifc.req_op     = '0;
    ifc.req_addr   = '0;
    ifc.req_wdata  = '0;
    ifc3.req       = '0;
    ifc3.req_op    = '0;
    ifc3.req_addr  = '0;
    ifc3.req_wdata = '0;
    $display("[TB] starting dmem_arbiter directed tests");
    test_reset();
    test_write_read();
    test_contention();
    test_access_lat();
    test_reset_mid_access();
    test_illegal_op();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
